// File: rtl/immediate_encoder_pkg.sv
// Shared types and widths for the immediate encoder: FSM states, constant classes
// and the classifier result bundle.
package immediate_encoder_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IMM_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        HI   = 2'd2,
        LO   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CLS_SIGN  = 2'd0,
        CLS_ZERO  = 2'd1,
        CLS_SPLIT = 2'd2
    } cls_e;

    // Classifier result: class plus the fields of the first and second beat.
    typedef struct packed {
        cls_e             cls;
        logic             cs0;
        logic [IMM_W-1:0] imm0;
        logic [IMM_W-1:0] imm1;
    } enc_t;

endpackage

// File: rtl/imm_classify.sv
// Combinational classifier: maps an 8-bit constant to its extension class and the
// immediate fields of its first and (for split constants) second beat.
module imm_classify
    import immediate_encoder_pkg::*;
(
    input  logic [DATA_W-1:0] const_i,
    output enc_t              enc_o
);

    always_comb begin
        enc_o      = '0;
        enc_o.cls  = CLS_SPLIT;
        enc_o.imm1 = IMM_W'(const_i[1:0]);
        // Sign extension is preferred where both extensions would reproduce the value.
        if (const_i[7:5] == 3'b000 || const_i[7:5] == 3'b111) begin
            enc_o.cls  = CLS_SIGN;
            enc_o.cs0  = 1'b1;
            enc_o.imm0 = const_i[IMM_W-1:0];
        end else if (const_i[7:6] == 2'b00) begin
            enc_o.cls  = CLS_ZERO;
            enc_o.imm0 = const_i[IMM_W-1:0];
        end else begin
            enc_o.imm0 = const_i[DATA_W-1:2];
        end
    end

endmodule

// File: rtl/immediate_encoder.sv
// Encodes 8-bit constants into 6-bit immediate beats with a CS extension select,
// splitting constants that fit neither extension into a HI/LO pair.
module immediate_encoder
    import immediate_encoder_pkg::*;
#(
    parameter int unsigned SAT_MAX = 255
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] ConstIn,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              CS,
    output logic [IMM_W-1:0]  ImmediateData,
    output logic              Split,
    output logic              Last,
    output logic [DATA_W-1:0] SplitCount
);

    localparam logic [DATA_W-1:0] SAT_V = DATA_W'(SAT_MAX);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] const_q, const_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic              rdy_q;
    logic [DATA_W-1:0] cls_src;
    enc_t              enc;

    // While idle the incoming constant is classified; otherwise the held one drives the beats.
    assign cls_src = (state_q == IDLE) ? ConstIn : const_q;

    imm_classify u_classify (
        .const_i (cls_src),
        .enc_o   (enc)
    );

    assign SplitCount = cnt_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            const_q <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            const_q <= const_d;
            cnt_q   <= cnt_d;
            rdy_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        const_d       = const_q;
        cnt_d         = cnt_q;
        InReady       = 1'b0;
        OutValid      = 1'b0;
        CS            = 1'b0;
        ImmediateData = '0;
        Split         = 1'b0;
        Last          = 1'b0;
        unique case (state_q)
            IDLE: begin
                InReady = rdy_q;
                if (InValid && rdy_q) begin
                    const_d = ConstIn;
                    if (enc.cls == CLS_SPLIT) begin
                        state_d = HI;
                        if (cnt_q != SAT_V) begin
                            cnt_d = cnt_q + DATA_W'(1);
                        end
                    end else begin
                        state_d = ONE;
                    end
                end
            end
            ONE: begin
                OutValid      = 1'b1;
                CS            = enc.cs0;
                ImmediateData = enc.imm0;
                Last          = 1'b1;
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            HI: begin
                OutValid      = 1'b1;
                ImmediateData = enc.imm0;
                Split         = 1'b1;
                if (OutReady) begin
                    state_d = LO;
                end
            end
            LO: begin
                OutValid      = 1'b1;
                ImmediateData = enc.imm1;
                Split         = 1'b1;
                Last          = 1'b1;
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_immediate_encoder.sv
// Self-checking bench for immediate_encoder: directed vectors, backpressure, reset
// mid-sequence, randomized constants against an arithmetic model, and saturation.
module tb_immediate_encoder;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       InValid;
    logic       InReady;
    logic [7:0] ConstIn;
    logic       OutValid;
    logic       OutReady;
    logic       CS;
    logic [5:0] ImmediateData;
    logic       Split;
    logic       Last;
    logic [7:0] SplitCount;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_m    = 0;

    typedef struct {
        logic [7:0] c;
        int         nb;
        logic       cs0;
        logic [5:0] imm0;
        logic [5:0] imm1;
    } vec_t;

    vec_t vecs[13];

    always #5 Clk = ~Clk;

    immediate_encoder #(.SAT_MAX(255)) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .InValid       (InValid),
        .InReady       (InReady),
        .ConstIn       (ConstIn),
        .OutValid      (OutValid),
        .OutReady      (OutReady),
        .CS            (CS),
        .ImmediateData (ImmediateData),
        .Split         (Split),
        .Last          (Last),
        .SplitCount    (SplitCount)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model built from the value ranges of each extension class.
    task automatic model(input logic [7:0] c, output int nb, output logic cs0,
                         output logic [5:0] imm0, output logic [5:0] imm1);
        int v;
        v = int'(c);
        imm1 = 6'd0;
        if (v < 32 || v >= 224) begin
            nb = 1; cs0 = 1'b1; imm0 = 6'(v % 64);
        end else if (v < 64) begin
            nb = 1; cs0 = 1'b0; imm0 = 6'(v);
        end else begin
            nb = 2; cs0 = 1'b0; imm0 = 6'(v / 4); imm1 = 6'(v % 4);
        end
    endtask

    task automatic run_const(input logic [7:0] c, input int nb, input logic cs0,
                             input logic [5:0] imm0, input logic [5:0] imm1,
                             input int stall0, input int rmax, input bit noise);
        chk("in_ready_idle", 32'(InReady), 32'd1);
        InValid = 1'b1;
        ConstIn = c;
        @(negedge Clk);
        InValid = 1'b0;
        ConstIn = 8'($urandom);
        if (nb == 2 && cnt_m < 255) cnt_m++;
        for (int b = 0; b < nb; b++) begin
            int st;
            st = (b == 0 ? stall0 : 0) + (rmax > 0 ? int'($urandom_range(0, rmax)) : 0);
            for (int k = 0; k <= st; k++) begin
                OutReady = (k == st);
                if (noise) begin
                    InValid = 1'($urandom);
                    ConstIn = 8'($urandom);
                end
                chk("out_valid", 32'(OutValid), 32'd1);
                chk("cs", 32'(CS), 32'(b == 0 ? cs0 : 1'b0));
                chk("imm", 32'(ImmediateData), 32'(b == 0 ? imm0 : imm1));
                chk("split", 32'(Split), 32'(nb == 2));
                chk("last", 32'(Last), 32'(b == nb - 1));
                chk("in_ready_busy", 32'(InReady), 32'd0);
                chk("split_count", 32'(SplitCount), 32'(cnt_m));
                @(negedge Clk);
            end
        end
        InValid = 1'b0;
        chk("done_out_valid", 32'(OutValid), 32'd0);
        chk("done_in_ready", 32'(InReady), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nb;
        logic       cs0;
        logic [5:0] imm0, imm1;
        logic [7:0] c;

        vecs = '{
            '{8'h07, 1, 1'b1, 6'h07, 6'h00},
            '{8'hE7, 1, 1'b1, 6'h27, 6'h00},
            '{8'h27, 1, 1'b0, 6'h27, 6'h00},
            '{8'h1F, 1, 1'b1, 6'h1F, 6'h00},
            '{8'h9B, 2, 1'b0, 6'h26, 6'h03},
            '{8'h00, 1, 1'b1, 6'h00, 6'h00},
            '{8'hFF, 1, 1'b1, 6'h3F, 6'h00},
            '{8'h20, 1, 1'b0, 6'h20, 6'h00},
            '{8'h3F, 1, 1'b0, 6'h3F, 6'h00},
            '{8'h40, 2, 1'b0, 6'h10, 6'h00},
            '{8'hDF, 2, 1'b0, 6'h37, 6'h03},
            '{8'hE0, 1, 1'b1, 6'h20, 6'h00},
            '{8'h1E, 1, 1'b1, 6'h1E, 6'h00}
        };

        Rst_n    = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b0;
        ConstIn  = 8'h00;
        repeat (2) @(negedge Clk);
        chk("rst_in_ready", 32'(InReady), 32'd0);
        chk("rst_out_valid", 32'(OutValid), 32'd0);
        chk("rst_cs", 32'(CS), 32'd0);
        chk("rst_imm", 32'(ImmediateData), 32'd0);
        chk("rst_split", 32'(Split), 32'd0);
        chk("rst_last", 32'(Last), 32'd0);
        chk("rst_split_count", 32'(SplitCount), 32'd0);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("post_rst_in_ready", 32'(InReady), 32'd1);
        chk("post_rst_out_valid", 32'(OutValid), 32'd0);

        // Directed vectors with OutReady held high.
        foreach (vecs[i])
            run_const(vecs[i].c, vecs[i].nb, vecs[i].cs0, vecs[i].imm0, vecs[i].imm1, 0, 0, 1'b0);

        // HI beat held under five cycles of backpressure.
        run_const(8'h80, 2, 1'b0, 6'h20, 6'h00, 5, 0, 1'b0);

        // Reset between HI and LO beats discards the constant.
        OutReady = 1'b1;
        InValid  = 1'b1;
        ConstIn  = 8'hC4;
        @(negedge Clk);
        InValid = 1'b0;
        chk("c4_hi_imm", 32'(ImmediateData), 32'h31);
        chk("c4_hi_last", 32'(Last), 32'd0);
        @(negedge Clk);
        chk("c4_lo_present", 32'(Last), 32'd1);
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(OutValid), 32'd0);
        chk("mid_rst_in_ready", 32'(InReady), 32'd0);
        chk("mid_rst_split", 32'(Split), 32'd0);
        chk("mid_rst_count", 32'(SplitCount), 32'd0);
        cnt_m = 0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        chk("rerst_in_ready", 32'(InReady), 32'd1);
        chk("rerst_out_valid", 32'(OutValid), 32'd0);
        @(negedge Clk);
        chk("rerst_no_lo", 32'(OutValid), 32'd0);
        chk("rerst_count", 32'(SplitCount), 32'd0);

        // Random constants, random stalls, producer noise while busy.
        for (int n = 0; n < 200; n++) begin
            c = 8'($urandom);
            model(c, nb, cs0, imm0, imm1);
            run_const(c, nb, cs0, imm0, imm1, 0, 3, 1'b1);
        end

        // Back-to-back split constants drive the counter into saturation.
        for (int n = 0; n < 300; n++) begin
            c = 8'($urandom_range(64, 223));
            model(c, nb, cs0, imm0, imm1);
            run_const(c, nb, cs0, imm0, imm1, 0, 0, 1'b0);
        end
        chk("sat_count", 32'(SplitCount), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
